// File: rtl/multi_count_pkg.sv
// Shared defaults and encodings for the multi-channel counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multi_count_pkg;

   // Parameter defaults used by the top and the channel sub-module
   localparam int WIDTH_DEF    = 64;
   localparam int CHANNELS_DEF = 4;
   localparam int PRE_W_DEF    = 8;

   // Direction encodings carried on Up
   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   // Overflow mode encodings carried on Sat
   localparam logic WRAP = 1'b0;
   localparam logic SAT  = 1'b1;

endpackage

// File: rtl/multi_count_channel.sv
// One counter channel: count, prescaler, sticky overflow flag and step tick.
// Latency: one edge from a qualifying cycle to the new count and tick.
// Backpressure: none; the channel acts on every edge where it is selected.
module count_channel
   import multi_count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             en,
   input  logic             up,
   input  logic             sat,
   input  logic [PRE_W-1:0] div,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_nxt;
   logic [WIDTH-1:0] count_nxt;
   logic             ovf_nxt;
   logic             tick_nxt;

   // Next-state: clear beats load beats step; unselected or idle channels hold
   always_comb begin
      count_nxt = count;
      pre_nxt   = pre_q;
      ovf_nxt   = ovf;
      tick_nxt  = 1'b0;
      if (sel) begin
         if (clr) begin
            count_nxt = '0;
            pre_nxt   = '0;
            ovf_nxt   = 1'b0;
         end else if (load) begin
            count_nxt = load_val;
            pre_nxt   = '0;
         end else if (en) begin
            // >= rather than == so a Div lowered below the prescaler steps at once
            if (pre_q >= div) begin
               pre_nxt  = '0;
               tick_nxt = 1'b1;
               if (up == UP) begin
                  if (&count) begin
                     ovf_nxt   = 1'b1;
                     count_nxt = (sat == SAT) ? count : '0;
                  end else begin
                     count_nxt = count + CNT_ONE;
                  end
               end else begin
                  if (count == '0) begin
                     ovf_nxt   = 1'b1;
                     count_nxt = (sat == SAT) ? count : '1;
                  end else begin
                     count_nxt = count - CNT_ONE;
                  end
               end
            end else begin
               pre_nxt = pre_q + PRE_ONE;
            end
         end
      end
   end

   // State register; reset discards any partial prescale progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         pre_q <= '0;
         ovf   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         count <= count_nxt;
         pre_q <= pre_nxt;
         ovf   <= ovf_nxt;
         tick  <= tick_nxt;
      end
   end

endmodule

// File: rtl/multi_count.sv
// Bank of independent prescaled up/down counters sharing one control port.
// Latency: one edge from control inputs to registered count/tick/ovf.
// Backpressure: none; one channel is addressed per cycle via Slt.
module multi_count
   import multi_count_pkg::*;
#(
   parameter  int WIDTH    = WIDTH_DEF,
   parameter  int CHANNELS = CHANNELS_DEF,
   parameter  int PRE_W    = PRE_W_DEF,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      En,
   input  logic [SEL_W-1:0]          Slt,
   input  logic                      Up,
   input  logic                      Sat,
   input  logic [PRE_W-1:0]          Div,
   input  logic                      Load,
   input  logic [WIDTH-1:0]          LoadVal,
   input  logic                      Clr,
   output logic [CHANNELS*WIDTH-1:0] Output,
   output logic [CHANNELS-1:0]       Tick,
   output logic [CHANNELS-1:0]       Ovf
);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      // Slt values at or above CHANNELS never match any k, so they select nothing
      logic sel;
      assign sel = (int'(Slt) == k);

      count_channel #(
         .WIDTH (WIDTH),
         .PRE_W (PRE_W)
      ) u_ch (
         .clk      (Clk),
         .rst      (Reset),
         .sel      (sel),
         .en       (En),
         .up       (Up),
         .sat      (Sat),
         .div      (Div),
         .load     (Load),
         .load_val (LoadVal),
         .clr      (Clr),
         .count    (Output[k*WIDTH +: WIDTH]),
         .tick     (Tick[k]),
         .ovf      (Ovf[k])
      );
   end

endmodule

// File: tb/tb_multi_count.sv
// Directed self-checking bench for multi_count (WIDTH=8, CHANNELS=4, PRE_W=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Reset is also pulsed between edges to check its asynchronous behaviour.
module tb_multi_count;
   import multi_count_pkg::*;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int PRE_W    = 4;
   localparam int SEL_W    = 2;

   logic                      Clk = 1'b0;
   logic                      Reset;
   logic                      En;
   logic [SEL_W-1:0]          Slt;
   logic                      Up;
   logic                      Sat;
   logic [PRE_W-1:0]          Div;
   logic                      Load;
   logic [WIDTH-1:0]          LoadVal;
   logic                      Clr;
   logic [CHANNELS*WIDTH-1:0] Output;
   logic [CHANNELS-1:0]       Tick;
   logic [CHANNELS-1:0]       Ovf;

   int n_tests = 0;
   int n_fail  = 0;

   multi_count #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .PRE_W    (PRE_W)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .En      (En),
      .Slt     (Slt),
      .Up      (Up),
      .Sat     (Sat),
      .Div     (Div),
      .Load    (Load),
      .LoadVal (LoadVal),
      .Clr     (Clr),
      .Output  (Output),
      .Tick    (Tick),
      .Ovf     (Ovf)
   );

   always #5 Clk = ~Clk;

   function automatic logic [WIDTH-1:0] ch(input int k);
      return Output[k*WIDTH +: WIDTH];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; En = 1'b0; Slt = '0; Up = UP; Sat = WRAP; Div = '0;
      Load = 1'b0; LoadVal = '0; Clr = 1'b0;
      #2;
      chk("reset_output", 64'(Output), 64'h0);
      chk("reset_tick", 64'(Tick), 64'h0);
      chk("reset_ovf", 64'(Ovf), 64'h0);
      edge_step();
      Reset = 1'b0;

      // ch0 unprescaled count-up: one step per edge
      En = 1'b1; Slt = 2'd0; Up = UP; Div = 4'd0;
      for (int i = 1; i <= 5; i++) begin
         edge_step();
         chk($sformatf("ch0_count_%0d", i), 64'(ch(0)), 64'(i));
         chk($sformatf("ch0_tick_%0d", i), 64'(Tick), 64'b0001);
      end
      chk("ch1_3_idle", 64'(Output[CHANNELS*WIDTH-1:WIDTH]), 64'h0);

      // ch1 prescaled by 4: ticks on edges 4, 8, 12
      Slt = 2'd1; Div = 4'd3;
      for (int i = 1; i <= 12; i++) begin
         edge_step();
         chk($sformatf("ch1_tick_%0d", i), 64'(Tick), (i % 4 == 0) ? 64'b0010 : 64'b0000);
         chk($sformatf("ch1_count_%0d", i), 64'(ch(1)), 64'(i / 4));
      end
      chk("ch0_held", 64'(ch(0)), 64'd5);

      // ch2 wrap through max
      En = 1'b0; Slt = 2'd2; Load = 1'b1; LoadVal = 8'd254; Div = 4'd0;
      edge_step();
      chk("ch2_load", 64'(ch(2)), 64'd254);
      chk("ch2_load_tick", 64'(Tick), 64'h0);
      Load = 1'b0; En = 1'b1; Up = UP; Sat = WRAP;
      edge_step();
      chk("ch2_wrap_s1", 64'(ch(2)), 64'd255);
      chk("ch2_wrap_ovf_s1", 64'(Ovf), 64'b0000);
      edge_step();
      chk("ch2_wrap_s2", 64'(ch(2)), 64'd0);
      chk("ch2_wrap_tick_s2", 64'(Tick), 64'b0100);
      edge_step();
      chk("ch2_wrap_s3", 64'(ch(2)), 64'd1);
      chk("ch2_wrap_ovf", 64'(Ovf), 64'b0100);

      // ch2 saturate at max, tick on every held step
      En = 1'b0; Load = 1'b1; LoadVal = 8'd254;
      edge_step();
      Load = 1'b0; En = 1'b1; Sat = SAT;
      for (int i = 1; i <= 3; i++) begin
         edge_step();
         chk($sformatf("ch2_sat_s%0d", i), 64'(ch(2)), 64'd255);
         chk($sformatf("ch2_sat_tick_s%0d", i), 64'(Tick), 64'b0100);
      end
      chk("ch2_sat_ovf", 64'(Ovf), 64'b0100);

      // ch3 underflow wrap, then clear with En low
      Slt = 2'd3; Up = DOWN; Sat = WRAP;
      edge_step();
      chk("ch3_underflow", 64'(ch(3)), 64'd255);
      chk("ch3_underflow_ovf", 64'(Ovf), 64'b1100);
      En = 1'b0; Clr = 1'b1;
      edge_step();
      Clr = 1'b0;
      chk("ch3_clr_count", 64'(ch(3)), 64'd0);
      chk("ch3_clr_ovf", 64'(Ovf), 64'b0100);

      // Clr wins over Load; Load wins over a step
      Slt = 2'd0; Load = 1'b1; LoadVal = 8'd7;
      edge_step();
      chk("ch0_load7", 64'(ch(0)), 64'd7);
      Clr = 1'b1; LoadVal = 8'd99;
      edge_step();
      Clr = 1'b0;
      chk("ch0_clr_over_load", 64'(ch(0)), 64'd0);
      Slt = 2'd3; En = 1'b1; Up = UP; LoadVal = 8'h5a;
      edge_step();
      Load = 1'b0; En = 1'b0;
      chk("ch3_load_over_step", 64'(ch(3)), 64'h5a);
      chk("load_only_ch3", 64'(Output[3*WIDTH-1:0]), {40'h0, 8'd255, 8'd3, 8'd0});
      chk("load_tick", 64'(Tick), 64'h0);

      // Lowering Div below the prescaler steps on the next qualifying edge
      Slt = 2'd2; Sat = WRAP; LoadVal = 8'd10; Load = 1'b1;
      edge_step();
      Load = 1'b0; En = 1'b1; Div = 4'd3;
      edge_step();
      edge_step();
      chk("ch2_pre_no_step", 64'(ch(2)), 64'd10);
      Div = 4'd1;
      edge_step();
      chk("ch2_div_drop", 64'(ch(2)), 64'd11);
      chk("ch2_div_drop_tick", 64'(Tick), 64'b0100);

      // Asynchronous reset mid-prescale on ch1 (prescaler reaches 2)
      Slt = 2'd1; Div = 4'd3;
      edge_step();
      edge_step();
      #2;
      Reset = 1'b1;
      #1;
      chk("areset_output", 64'(Output), 64'h0);
      chk("areset_tick_ovf", {32'(Tick), 32'(Ovf)}, 64'h0);
      #1;
      Reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         edge_step();
         chk($sformatf("post_reset_hold_%0d", i), 64'(ch(1)), 64'd0);
      end
      edge_step();
      chk("post_reset_step", 64'(ch(1)), 64'd1);
      chk("post_reset_tick", 64'(Tick), 64'b0010);

      // En low freezes everything
      En = 1'b0;
      edge_step();
      edge_step();
      chk("freeze_count", 64'(ch(1)), 64'd1);
      chk("freeze_tick", 64'(Tick), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_count.md
MULTI_COUNT -- requirements
Module: multi_count

Interface
REQ-001 Parameter WIDTH, default 64, counter width per channel in bits.
REQ-002 Parameter CHANNELS, default 4, number of independent counter channels (>=2).
REQ-003 Parameter PRE_W, default 8, prescaler width in bits; SEL_W = clog2(CHANNELS), derived and not overridable.
REQ-004 Clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 En  in  1  count enable for the selected channel.
REQ-007 Slt  in  SEL_W  channel select; values >= CHANNELS select no channel.
REQ-008 Up  in  1  direction: 1 increment, 0 decrement.
REQ-009 Sat  in  1  overflow mode: 1 saturate, 0 wrap.
REQ-010 Div  in  PRE_W  prescale: selected channel steps once per Div+1 qualifying cycles.
REQ-011 Load  in  1  load LoadVal into the selected channel.
REQ-012 LoadVal  in  WIDTH  load value.
REQ-013 Clr  in  1  clear the selected channel's count, prescaler and overflow flag.
REQ-014 Output  out  CHANNELS*WIDTH  registered counts; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-015 Tick  out  CHANNELS  registered one-cycle pulse per channel, high in the cycle a new stepped count is visible.
REQ-016 Ovf  out  CHANNELS  sticky per-channel wrap/saturation flag.

Function
REQ-017 Only the channel k = Slt is affected in a cycle; all other channels hold count, prescaler and flag; Tick is 0 for them.
REQ-018 Per-edge priority for the selected channel SHALL be Clr > Load > step; Clr and Load act regardless of En.
REQ-019 Clr: count <= 0, prescaler <= 0, Ovf[k] <= 0, Tick[k] <= 0.
REQ-020 Load: count <= LoadVal, prescaler <= 0, Ovf[k] unchanged, Tick[k] <= 0.
REQ-021 Qualifying cycle = En=1, Slt valid, Clr=0, Load=0; on such a cycle, if prescaler >= Div then prescaler <= 0 and the count steps, else prescaler increments.
REQ-022 The >= comparison SHALL make a Div reduced below the current prescaler value take effect on the next qualifying cycle, with no multi-cycle overshoot.
REQ-023 Div = 0 SHALL step on every qualifying cycle (latency one edge, as an unprescaled counter).
REQ-024 Step, Up=1: count+1; at 2^WIDTH-1, Sat=0 wraps to 0 and Sat=1 holds at 2^WIDTH-1; Ovf[k] <= 1 in both cases.
REQ-025 Step, Up=0: count-1; at 0, Sat=0 wraps to 2^WIDTH-1 and Sat=1 holds at 0; Ovf[k] <= 1 in both cases.
REQ-026 Tick[k] SHALL pulse on every step, including saturated holds.
REQ-027 Ovf[k] SHALL remain set until Clr on channel k or Reset.
REQ-028 Up, Sat and Div SHALL be sampled per edge; changing them mid-prescale keeps the prescaler value.
REQ-029 En=0 with Clr=0 and Load=0 SHALL freeze all state; Tick all 0.

Reset
REQ-030 Reset=1 SHALL immediately force all counts, prescalers, Ovf and Tick to 0, independent of Clk.
REQ-031 Reset asserted mid-prescale or mid-pulse SHALL discard partial prescale progress; the first qualifying edge after release counts as prescale cycle 1.

Structure
REQ-032 Shared package multi_count_pkg SHALL hold the parameter defaults, the direction encodings (UP=1, DOWN=0) and the mode encodings (WRAP=0, SAT=1).
REQ-033 One sub-module count_channel (count, prescaler, Ovf, Tick for one channel) SHALL be instantiated CHANNELS times via generate; the top holds only select decode and output packing.

Verification (bench WIDTH=8, CHANNELS=4, PRE_W=4)
REQ-034 Reset, then En=1, Slt=0, Up=1, Div=0 for 5 edges -> ch0=5, Tick[0] high 5 cycles, ch1..3=0.
REQ-035 Slt=1, Div=3, En=1 for 12 edges -> ch1=3, Tick[1] high on edges 4, 8 and 12 only.
REQ-036 Load LoadVal=254 into ch2, then 3 steps Up=1, Sat=0 -> 255, 0, 1; Ovf[2]=1. Repeat with Sat=1 -> 255, 255, 255; Tick every step.
REQ-037 ch3=0, Up=0, Sat=0, one step -> ch3=255, Ovf[3]=1; then Clr with En=0 -> ch3=0, Ovf[3]=0.
REQ-038 Load and Clr asserted together on ch0=7 -> ch0=0; Slt=3 and En=1 with Load=1 -> only ch3 loaded.
REQ-039 Reset pulsed between clock edges mid-prescale (Div=3, prescaler=2) -> outputs 0 before the next edge; a step occurs only after 4 further qualifying edges.
